cache_line_ctrl: RTL and testbench
==================================

# cache_line_ctrl

Per-core direct-mapped write-back cache controller, 4 lines × 32-bit, sitting between a core's load/store port and the shared 16-word main memory. It serves core reads and writes on hits. On a miss it evicts a dirty victim through one main-memory write port, then refills through one combinational read port, capturing the returned tag bits. It also supports a full flush of dirty lines back to memory.

## Interface
Parameters:
- STAT_W, 16, width of hit/miss counters (used only with CACHE_STATS_EN).

Ports:
- clk  in  1  system clock, all state on posedge.
- rst  in  1  reset; asynchronous, active-high.
- cpu_req  in  1  request valid.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  4  word address; [3:2] tag, [1:0] index.
- cpu_wdata  in  32  write data.
- cpu_rdata  out  32  read data, valid while cpu_done=1.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_busy  out  1  controller not in IDLE; requests ignored.
- flush  in  1  write back all dirty lines.
- flush_done  out  1  one-cycle pulse at flush completion.
- mem_raddr  out  4  main-memory read address.
- mem_rdata  in  32  main-memory read data, combinational from mem_raddr.
- mem_rtag  in  2  tag bits returned with mem_rdata (= mem_raddr[3:2]).
- mem_we  out  1  main-memory write enable, one cycle per write.
- mem_waddr  out  4  write address.
- mem_wdata  out  32  write data.
- hit_count, miss_count  out  STAT_W  (CACHE_STATS_EN only).

## Operation
- Per line: valid, dirty, tag[1:0], data[31:0].
- States: IDLE, WB, FILL, FLUSH.
- IDLE: at posedge, flush=1 has priority → FLUSH with line pointer=0. Otherwise cpu_req=1 → latch we/addr/wdata and do lookup. Hit = valid && tag==addr[3:2].
  - Read hit: cpu_rdata ← data; stay IDLE.
  - Write hit: data ← wdata, dirty ← 1; stay IDLE.
  - Miss with victim valid&&dirty → WB. Otherwise → FILL.
- WB (1 cycle): mem_we=1, mem_waddr={victim tag,index}, mem_wdata=victim data; at edge dirty ← 0 → FILL.
- FILL (1 cycle): mem_raddr={req tag,index}. At edge: data ← mem_rdata, tag ← mem_rtag, valid ← 1, then apply the pending op. Read: cpu_rdata ← mem_rdata, dirty=0. Write: data ← wdata, dirty=1. → IDLE.
- FLUSH (4 cycles, index 0..3): for each valid&&dirty line, mem_we=1, addr={tag,index}, data=line data, and the edge clears dirty. Clean lines produce no write. After index 3 → IDLE. Valid bits are retained.
- mem_we=0, mem_raddr=0, mem_waddr=0, mem_wdata=0 whenever not driven as above.

## Timing
- Reset values: all valid/dirty/tag/data=0, state IDLE, cpu_rdata=0, cpu_done=0, cpu_busy=0, flush_done=0, mem_* outputs 0, counters 0.
- cpu_busy = (state != IDLE), combinational from state.
- Latency, measured from the accept edge to cpu_done high: hit 1 cycle, clean miss 2, dirty miss 3.
- Completion: cpu_done is registered and asserted for exactly one cycle, the cycle after the completing edge. In that cycle cpu_busy=0 and a new request may be accepted (back-to-back).
- flush_done pulses the cycle after the index-3 edge.
- cpu_req/flush while busy: ignored. The requester holds the request until it is accepted.
- Simultaneous flush and cpu_req in IDLE: flush wins; cpu_req is not accepted that cycle.
- Reset mid-operation: the transaction is dropped, no cpu_done is issued, and mem_we deasserts asynchronously. Dirty data is lost.

## Configuration
- CACHE_STATS_EN defined: hit_count and miss_count ports exist. Each increments by 1 at the accept edge of a hit or miss respectively and saturates at all-ones. Flush does not count.
- Not defined: ports and counters absent; all other behaviour identical.

## Test plan
- Memory model preset mem[5]=3. Read addr 5 → FILL cycle shows mem_raddr=5, cpu_rdata=3 with cpu_done 2 cycles after accept. Repeat read addr 5 → hit, cpu_done 1 cycle after accept, mem_raddr stays 0.
- Write 0xA5 to addr 1 (miss, FILL) → cpu_done at 2 cycles, no mem_we. Then read addr 5 → WB cycle with mem_we=1, mem_waddr=1, mem_wdata=0xA5; FILL; cpu_rdata=3 at 3 cycles.
- Dirty lines at index 0 (addr 4, 0x11) and index 2 (addr 14, 0x22); pulse flush → exactly two mem_we cycles (4/0x11, 14/0x22), flush_done 4 cycles after accept. Re-flush → zero writes.
- Assert rst during WB → mem_we=0 immediately and no cpu_done. After release, read of the previously dirty address misses.
- Back-to-back: new cpu_req presented in the cpu_done cycle is accepted at that edge. flush and cpu_req together → flush runs first.
- CACHE_STATS_EN: sequence of 3 hits, 2 misses → hit_count=3, miss_count=2.

Source files
------------

// File: rtl/cache_line_ctrl.sv
// Direct-mapped write-back cache controller, 4 lines x 32 bits, 16-word backing memory.
// Optional hit/miss counters are built when CACHE_STATS_EN is defined.
module cache_line_ctrl #(
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [3:0]        cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_done,
    output logic              cpu_busy,
    input  logic              flush,
    output logic              flush_done,
    output logic [3:0]        mem_raddr,
    input  logic [31:0]       mem_rdata,
    input  logic [1:0]        mem_rtag,
    output logic              mem_we,
    output logic [3:0]        mem_waddr,
`ifdef CACHE_STATS_EN
    output logic [STAT_W-1:0] hit_count,
    output logic [STAT_W-1:0] miss_count,
`endif
    output logic [31:0]       mem_wdata
);

    typedef enum logic [1:0] {IDLE, WB, FILL, FLUSH} state_t;

    state_t           state_q, state_d;
    logic [3:0]       valid_q, valid_d, dirty_q, dirty_d;
    logic [3:0][1:0]  tag_q, tag_d;
    logic [3:0][31:0] data_q, data_d;
    logic             req_we_q, req_we_d;
    logic [3:0]       req_addr_q, req_addr_d;
    logic [31:0]      req_wdata_q, req_wdata_d;
    logic [1:0]       fidx_q, fidx_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             done_q, done_d, fdone_q, fdone_d;
    logic [1:0]       idx, ridx;
    logic             hit, is_hit, is_miss;

    assign idx  = cpu_addr[1:0];
    assign ridx = req_addr_q[1:0];
    assign hit  = valid_q[idx] && (tag_q[idx] == cpu_addr[3:2]);

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        tag_d       = tag_q;
        data_d      = data_q;
        req_we_d    = req_we_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        fidx_d      = fidx_q;
        rdata_d     = rdata_q;
        done_d      = 1'b0;
        fdone_d     = 1'b0;
        is_hit      = 1'b0;
        is_miss     = 1'b0;
        mem_raddr   = 4'd0;
        mem_we      = 1'b0;
        mem_waddr   = 4'd0;
        mem_wdata   = 32'd0;
        case (state_q)
            IDLE: begin
                if (flush) begin
                    state_d = FLUSH;
                    fidx_d  = 2'd0;
                end else if (cpu_req) begin
                    req_we_d    = cpu_we;
                    req_addr_d  = cpu_addr;
                    req_wdata_d = cpu_wdata;
                    if (hit) begin
                        is_hit = 1'b1;
                        done_d = 1'b1;
                        if (cpu_we) begin
                            data_d[idx]  = cpu_wdata;
                            dirty_d[idx] = 1'b1;
                        end else begin
                            rdata_d = data_q[idx];
                        end
                    end else begin
                        is_miss = 1'b1;
                        state_d = (valid_q[idx] && dirty_q[idx]) ? WB : FILL;
                    end
                end
            end
            WB: begin
                mem_we        = 1'b1;
                mem_waddr     = {tag_q[ridx], ridx};
                mem_wdata     = data_q[ridx];
                dirty_d[ridx] = 1'b0;
                state_d       = FILL;
            end
            FILL: begin
                mem_raddr     = req_addr_q;
                valid_d[ridx] = 1'b1;
                tag_d[ridx]   = mem_rtag;
                if (req_we_q) begin
                    data_d[ridx]  = req_wdata_q;
                    dirty_d[ridx] = 1'b1;
                end else begin
                    data_d[ridx]  = mem_rdata;
                    dirty_d[ridx] = 1'b0;
                    rdata_d       = mem_rdata;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            FLUSH: begin
                if (valid_q[fidx_q] && dirty_q[fidx_q]) begin
                    mem_we          = 1'b1;
                    mem_waddr       = {tag_q[fidx_q], fidx_q};
                    mem_wdata       = data_q[fidx_q];
                    dirty_d[fidx_q] = 1'b0;
                end
                fidx_d = fidx_q + 2'd1;
                if (fidx_q == 2'd3) begin
                    state_d = IDLE;
                    fdone_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            dirty_q     <= '0;
            tag_q       <= '0;
            data_q      <= '0;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            fidx_q      <= '0;
            rdata_q     <= '0;
            done_q      <= 1'b0;
            fdone_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            tag_q       <= tag_d;
            data_q      <= data_d;
            req_we_q    <= req_we_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            fidx_q      <= fidx_d;
            rdata_q     <= rdata_d;
            done_q      <= done_d;
            fdone_q     <= fdone_d;
        end
    end

    assign cpu_rdata  = rdata_q;
    assign cpu_done   = done_q;
    assign flush_done = fdone_q;
    assign cpu_busy   = (state_q != IDLE);

`ifdef CACHE_STATS_EN
    logic [STAT_W-1:0] hit_q, miss_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            if (is_hit && !(&hit_q))   hit_q  <= hit_q + 1'b1;
            if (is_miss && !(&miss_q)) miss_q <= miss_q + 1'b1;
        end
    end
    assign hit_count  = hit_q;
    assign miss_count = miss_q;
`else
    logic unused_stats;
    assign unused_stats = is_hit ^ is_miss;
`endif

endmodule

// File: tb/tb_cache_line_ctrl.sv
// Directed bench for cache_line_ctrl with a 16-word memory model.
module tb_cache_line_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, flush;
    logic [3:0]  cpu_addr;
    logic [31:0] cpu_wdata, cpu_rdata;
    logic        cpu_done, cpu_busy, flush_done;
    logic [3:0]  mem_raddr, mem_waddr;
    logic [31:0] mem_rdata, mem_wdata;
    logic [1:0]  mem_rtag;
    logic        mem_we;
`ifdef CACHE_STATS_EN
    logic [15:0] hit_count, miss_count;
`endif
    logic [31:0] mem [16];
    int checks = 0;
    int errors = 0;
    int nwr;

    always #5 clk = ~clk;

    cache_line_ctrl #(.STAT_W(16)) dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_done(cpu_done), .cpu_busy(cpu_busy), .flush(flush),
        .flush_done(flush_done), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .mem_rtag(mem_rtag), .mem_we(mem_we), .mem_waddr(mem_waddr),
`ifdef CACHE_STATS_EN
        .hit_count(hit_count), .miss_count(miss_count),
`endif
        .mem_wdata(mem_wdata)
    );

    assign mem_rdata = mem[mem_raddr];
    assign mem_rtag  = mem_raddr[3:2];
    always @(posedge clk) if (mem_we) mem[mem_waddr] <= mem_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic we, input logic [3:0] a, input logic [31:0] d);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h100 + i;
        mem[5] = 32'd3; mem[0] = 32'h77; mem[8] = 32'h88;
        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; flush = 1'b0;
        tick(); tick();
        chk("rst_done", cpu_done, 0); chk("rst_busy", cpu_busy, 0);
        chk("rst_rdata", cpu_rdata, 0); chk("rst_fdone", flush_done, 0);
        chk("rst_we", mem_we, 0); chk("rst_raddr", mem_raddr, 0);
        chk("rst_waddr", mem_waddr, 0); chk("rst_wdata", mem_wdata, 0);
        rst = 1'b0; tick();

        // clean read miss then hit
        req(0, 4'd5, 0); tick(); cpu_req = 1'b0;
        chk("rd5_busy", cpu_busy, 1); chk("rd5_raddr", mem_raddr, 5);
        chk("rd5_done_early", cpu_done, 0); chk("rd5_we", mem_we, 0);
        tick(); chk("rd5_done", cpu_done, 1); chk("rd5_rdata", cpu_rdata, 3); chk("rd5_nbusy", cpu_busy, 0);
        tick(); chk("rd5_pulse", cpu_done, 0);
        req(0, 4'd5, 0); tick(); cpu_req = 1'b0;
        chk("hit5_done", cpu_done, 1); chk("hit5_rdata", cpu_rdata, 3); chk("hit5_raddr", mem_raddr, 0);
        tick();

        // write miss fills line 1 dirty, then dirty eviction
        req(1, 4'd1, 32'hA5); tick(); cpu_req = 1'b0;
        chk("wr1_raddr", mem_raddr, 1); chk("wr1_we", mem_we, 0);
        tick(); chk("wr1_done", cpu_done, 1); chk("wr1_we2", mem_we, 0);
        req(0, 4'd5, 0); tick(); cpu_req = 1'b0;
        chk("wb_we", mem_we, 1); chk("wb_waddr", mem_waddr, 1); chk("wb_wdata", mem_wdata, 32'hA5);
        chk("wb_done", cpu_done, 0);
        tick(); chk("wbf_we", mem_we, 0); chk("wbf_raddr", mem_raddr, 5); chk("wbf_done", cpu_done, 0);
        tick(); chk("wbr_done", cpu_done, 1); chk("wbr_rdata", cpu_rdata, 3);
        chk("wb_mem1", mem[1], 32'hA5);

        // flush with two dirty lines, then an empty re-flush
        req(1, 4'd4, 32'h11); tick(); cpu_req = 1'b0; tick();
        req(1, 4'd14, 32'h22); tick(); cpu_req = 1'b0; tick();
        chk("fl_pre_done", cpu_done, 1);
        flush = 1'b1; tick(); flush = 1'b0; nwr = 0;
        chk("fl0_we", mem_we, 1); chk("fl0_waddr", mem_waddr, 4); chk("fl0_wdata", mem_wdata, 32'h11);
        nwr += int'(mem_we); tick(); nwr += int'(mem_we);
        chk("fl1_we", mem_we, 0); chk("fl1_busy", cpu_busy, 1);
        tick(); nwr += int'(mem_we);
        chk("fl2_waddr", mem_waddr, 14); chk("fl2_wdata", mem_wdata, 32'h22);
        tick(); nwr += int'(mem_we); chk("fl3_fdone", flush_done, 0);
        tick(); chk("fl_fdone", flush_done, 1); chk("fl_nwr", nwr, 2); chk("fl_busy", cpu_busy, 0);
        chk("fl_mem14", mem[14], 32'h22);
        tick(); chk("fl_fdone_pulse", flush_done, 0);
        flush = 1'b1; tick(); flush = 1'b0; nwr = 0;
        for (int i = 0; i < 4; i++) begin nwr += int'(mem_we); tick(); end
        chk("rfl_fdone", flush_done, 1); chk("rfl_nwr", nwr, 0);

        // back-to-back: next request offered during the done cycle
        req(0, 4'd0, 0); tick(); tick();
        chk("b2b_done1", cpu_done, 1); chk("b2b_rdata1", cpu_rdata, 32'h77);
        cpu_addr = 4'd14; tick(); cpu_req = 1'b0;
        chk("b2b_done2", cpu_done, 1); chk("b2b_rdata2", cpu_rdata, 32'h22);
        tick();

        // flush and request together: flush first, request held
        flush = 1'b1; req(0, 4'd4, 0); tick(); flush = 1'b0;
        chk("fr_busy", cpu_busy, 1); chk("fr_raddr", mem_raddr, 0);
        tick(); tick(); tick();
        chk("fr_done_none", cpu_done, 0);
        tick(); chk("fr_fdone", flush_done, 1); chk("fr_done0", cpu_done, 0);
        tick(); cpu_req = 1'b0; chk("fr_raddr4", mem_raddr, 4);
        tick(); chk("fr_done", cpu_done, 1); chk("fr_rdata", cpu_rdata, 32'h11);

        // reset during write-back drops the dirty line
        req(1, 4'd8, 32'h99); tick(); cpu_req = 1'b0; tick();
        req(0, 4'd12, 0); tick(); cpu_req = 1'b0;
        chk("rwb_we", mem_we, 1);
        rst = 1'b1; #1;
        chk("rwb_we_async", mem_we, 0); chk("rwb_busy", cpu_busy, 0);
        tick(); chk("rwb_done", cpu_done, 0); chk("rwb_mem8", mem[8], 32'h88);
        rst = 1'b0; tick();
        req(0, 4'd8, 0); tick(); cpu_req = 1'b0;
        chk("rwb_miss_busy", cpu_busy, 1); chk("rwb_miss_raddr", mem_raddr, 8);
        tick(); chk("rwb_rd_done", cpu_done, 1); chk("rwb_rdata", cpu_rdata, 32'h88);

`ifdef CACHE_STATS_EN
        rst = 1'b1; tick(); rst = 1'b0; tick();
        chk("st_rst_hit", hit_count, 0);
        req(0, 4'd5, 0); tick(); cpu_req = 1'b0; tick();
        for (int i = 0; i < 3; i++) begin req(0, 4'd5, 0); tick(); cpu_req = 1'b0; end
        req(0, 4'd9, 0); tick(); cpu_req = 1'b0; tick();
        flush = 1'b1; tick(); flush = 1'b0; tick(); tick(); tick(); tick();
        chk("st_hit", hit_count, 3); chk("st_miss", miss_count, 2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
